// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the equal-precision frequency meter controller.
package freq_meas_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;

    // Rd_Sel layout: [2] selects the snapshot, [1:0] selects the byte (0 = LSB)
    localparam int unsigned RD_SRC_BIT = 2;
    localparam logic        RD_SRC_FX  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StArm,
        StGate,
        StClose,
        StLatch,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/fx_edge_sync.sv
// Two-flop synchroniser for the asynchronous Fx input plus a registered
// one-cycle rising-edge pulse.
module fx_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic fx,
    output logic fx_edge
);

    // [0],[1]: synchroniser stages; [2]: previous synchronised level
    logic [2:0] sync_q;
    logic       edge_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], fx};
            edge_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign fx_edge = edge_q;

endmodule

// File: rtl/freq_meas_sequencer.sv
// Measurement sequencer: gates the external Fb/Fx counters on Fx edges,
// snapshots the results and hands them to the MCU via valid/ack and a byte port.
module freq_meas_sequencer
    import freq_meas_pkg::*;
#(
    parameter int unsigned GATE_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter int unsigned CNT_W          = CNT_W_DEFAULT
) (
    input  logic             CLOCK_50,
    input  logic             RST_n,
    input  logic             Start,
    input  logic             Cont,
    input  logic             Abort,
    input  logic             Fx,
    output logic             Fx_Edge,
    output logic             Cnt_Clr,
    output logic             Cnt_En,
    input  logic [CNT_W-1:0] Cnt_Fb_In,
    input  logic [CNT_W-1:0] Cnt_Fx_In,
    output logic             Busy,
    output logic             Data_Valid,
    output logic             Timeout,
    input  logic             Ack,
    input  logic [2:0]       Rd_Sel,
    output logic [7:0]       Rd_Data
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);

    state_e              state_q, state_d;
    logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]    snap_fb_q, snap_fx_q;
    logic [7:0]          rd_data_q, rd_data_d;
    logic                fx_edge;
    logic                latch_en;
    logic                snap_clr;

    fx_edge_sync u_fx_edge_sync (
        .clk     (CLOCK_50),
        .rst_n   (RST_n),
        .fx      (Fx),
        .fx_edge (fx_edge)
    );

    assign Fx_Edge = fx_edge;

    always_ff @(posedge CLOCK_50 or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= StIdle;
            gate_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    // Timers only advance while below their limit, so they saturate rather than wrap.
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        to_cnt_d   = to_cnt_q;
        latch_en   = 1'b0;
        snap_clr   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d  = StArm;
                to_cnt_d = TO_ONE;
            end
            StArm: begin
                if (fx_edge) begin
                    state_d    = StGate;
                    gate_cnt_d = GATE_ONE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d  = StErr;
                    snap_clr = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StGate: begin
                if (gate_cnt_q >= GATE_LAST) begin
                    if (fx_edge) begin
                        state_d = StLatch;
                    end else begin
                        state_d  = StClose;
                        to_cnt_d = TO_ONE;
                    end
                end else begin
                    gate_cnt_d = gate_cnt_q + 1'b1;
                end
            end
            StClose: begin
                if (fx_edge) begin
                    state_d = StLatch;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d  = StErr;
                    snap_clr = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StLatch: begin
                latch_en = 1'b1;
                state_d  = StDone;
            end
            StDone: begin
                if (Ack) begin
                    state_d = Cont ? StClear : StIdle;
                end
            end
            StErr: begin
                if (Ack) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything, including a coincident Start or capture.
        if (Abort) begin
            state_d  = StIdle;
            latch_en = 1'b0;
            snap_clr = 1'b0;
        end
    end

    always_comb begin
        Cnt_Clr    = 1'b0;
        Cnt_En     = 1'b0;
        Busy       = 1'b0;
        Data_Valid = 1'b0;
        Timeout    = 1'b0;
        unique case (state_q)
            StClear: begin
                Cnt_Clr = 1'b1;
                Busy    = 1'b1;
            end
            StArm: begin
                Busy = 1'b1;
            end
            StGate, StClose: begin
                Cnt_En = 1'b1;
                Busy   = 1'b1;
            end
            StLatch: begin
                Busy = 1'b1;
            end
            StDone: begin
                Data_Valid = 1'b1;
            end
            StErr: begin
                Data_Valid = 1'b1;
                Timeout    = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RST_n) begin
        if (!RST_n) begin
            snap_fb_q <= '0;
            snap_fx_q <= '0;
        end else if (snap_clr) begin
            snap_fb_q <= '0;
            snap_fx_q <= '0;
        end else if (latch_en) begin
            snap_fb_q <= Cnt_Fb_In;
            snap_fx_q <= Cnt_Fx_In;
        end
    end

    logic [CNT_W-1:0] rd_word;
    logic [CNT_W-1:0] rd_shift;

    always_comb begin
        rd_word   = (Rd_Sel[RD_SRC_BIT] == RD_SRC_FX) ? snap_fx_q : snap_fb_q;
        rd_shift  = rd_word >> {Rd_Sel[1:0], 3'b000};
        rd_data_d = rd_shift[7:0];
    end

    always_ff @(posedge CLOCK_50 or negedge RST_n) begin
        if (!RST_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign Rd_Data = rd_data_q;

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Directed, table-driven bench for freq_meas_sequencer with a behavioural
// Fb/Fx counter datapath and a periodic Fx generator.
module tb_freq_meas_sequencer;

    localparam int unsigned GATE = 100;
    localparam int unsigned TMO  = 400;
    localparam int unsigned W    = 32;

    logic         CLOCK_50   = 1'b0;
    logic         RST_n      = 1'b0;
    logic         Start      = 1'b0;
    logic         Cont       = 1'b0;
    logic         Abort      = 1'b0;
    logic         Fx         = 1'b0;
    logic         Ack        = 1'b0;
    logic [2:0]   Rd_Sel     = 3'b000;
    logic [W-1:0] Cnt_Fb_In  = '0;
    logic [W-1:0] Cnt_Fx_In  = '0;
    logic         Fx_Edge, Cnt_Clr, Cnt_En, Busy, Data_Valid, Timeout;
    logic [7:0]   Rd_Data;

    int n_checks = 0;
    int n_fail   = 0;
    int fx_period = 0;
    logic fx_manual = 1'b0;

    freq_meas_sequencer #(
        .GATE_CYCLES    (GATE),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (W)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RST_n      (RST_n),
        .Start      (Start),
        .Cont       (Cont),
        .Abort      (Abort),
        .Fx         (Fx),
        .Fx_Edge    (Fx_Edge),
        .Cnt_Clr    (Cnt_Clr),
        .Cnt_En     (Cnt_En),
        .Cnt_Fb_In  (Cnt_Fb_In),
        .Cnt_Fx_In  (Cnt_Fx_In),
        .Busy       (Busy),
        .Data_Valid (Data_Valid),
        .Timeout    (Timeout),
        .Ack        (Ack),
        .Rd_Sel     (Rd_Sel),
        .Rd_Data    (Rd_Data)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // External counter datapath
    always @(posedge CLOCK_50) begin
        if (Cnt_Clr) begin
            Cnt_Fb_In <= '0;
            Cnt_Fx_In <= '0;
        end else if (Cnt_En) begin
            Cnt_Fb_In <= Cnt_Fb_In + 1;
            if (Fx_Edge) Cnt_Fx_In <= Cnt_Fx_In + 1;
        end
    end

    // Fx source: period in clocks, or the manual level when period is 0
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge CLOCK_50);
            #3;
            if (fx_period == 0) begin
                Fx = fx_manual;
                ph = 0;
            end else begin
                Fx = (ph < fx_period / 2);
                ph = (ph + 1 >= fx_period) ? 0 : ph + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic read_snap(input logic src, output logic [31:0] v);
        v = '0;
        for (int b = 0; b < 4; b++) begin
            Rd_Sel = {src, 2'(b)};
            @(negedge CLOCK_50);
            v[8*b +: 8] = Rd_Data;
        end
    endtask

    task automatic measure(input bit do_start, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        Start = do_start;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLOCK_50);
            Start = 1'b0;
            cyc++;
            if (Data_Valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int          period;
        logic [31:0] fb;
        logic [31:0] fx;
        logic        to;
        int          cycles;
    } meas_vec_t;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] exp;
    } rd_vec_t;

    meas_vec_t mvec[3];
    rd_vec_t   rvec[8];

    initial begin
        int          cyc;
        bit          ok;
        logic [31:0] v;
        int          f_idx, e_idx, clr_cnt, bad;
        logic        fx_hist[10];
        logic        edge_hist[10];

        mvec[0] = '{10, 32'd100, 32'd10, 1'b0, 0};
        mvec[1] = '{0,  32'd0,   32'd0,  1'b1, TMO + 2};
        mvec[2] = '{7,  32'd105, 32'd15, 1'b0, 0};

        rvec[0] = '{3'b000, 8'h69};
        rvec[1] = '{3'b001, 8'h00};
        rvec[2] = '{3'b010, 8'h00};
        rvec[3] = '{3'b011, 8'h00};
        rvec[4] = '{3'b100, 8'h0F};
        rvec[5] = '{3'b101, 8'h00};
        rvec[6] = '{3'b110, 8'h00};
        rvec[7] = '{3'b111, 8'h00};

        // Reset state
        repeat (3) @(negedge CLOCK_50);
        chk("reset outputs", 32'({Fx_Edge, Cnt_Clr, Cnt_En, Busy, Data_Valid, Timeout, Rd_Data}),
            32'd0);
        RST_n = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        // Fx_Edge latency and width from a single manual rising edge
        fx_manual = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            fx_hist[i]   = Fx;
            edge_hist[i] = Fx_Edge;
        end
        f_idx = -1;
        e_idx = -1;
        for (int i = 9; i >= 0; i--) begin
            if (fx_hist[i]) f_idx = i;
            if (edge_hist[i]) e_idx = i;
        end
        chk("fx_edge latency", 32'(e_idx - f_idx), 32'd3);
        chk("fx_edge width", 32'(edge_hist[e_idx < 9 && e_idx >= 0 ? e_idx + 1 : 0]), 32'd0);
        fx_manual = 1'b0;
        repeat (5) @(negedge CLOCK_50);

        // Single measurements: normal, timeout, close-extended
        for (int k = 0; k < 3; k++) begin
            fx_period = mvec[k].period;
            repeat (20) @(negedge CLOCK_50);
            measure(1'b1, cyc, ok);
            chk($sformatf("m%0d valid", k), 32'(ok), 32'd1);
            if (mvec[k].cycles != 0) chk($sformatf("m%0d latency", k), 32'(cyc), mvec[k].cycles);
            chk($sformatf("m%0d timeout", k), 32'(Timeout), 32'(mvec[k].to));
            chk($sformatf("m%0d busy/en", k), 32'({Busy, Cnt_En}), 32'd0);
            read_snap(1'b0, v);
            chk($sformatf("m%0d fb", k), v, mvec[k].fb);
            read_snap(1'b1, v);
            chk($sformatf("m%0d fx", k), v, mvec[k].fx);
            // Ack with a coincident Start: Start must be ignored; Cont ignored in ERR
            Cont  = mvec[k].to;
            Ack   = 1'b1;
            Start = 1'b1;
            @(negedge CLOCK_50);
            Ack   = 1'b0;
            Start = 1'b0;
            Cont  = 1'b0;
            chk($sformatf("m%0d ack valid/to", k), 32'({Data_Valid, Timeout}), 32'd0);
            chk($sformatf("m%0d ack busy", k), 32'(Busy), 32'd0);
            @(negedge CLOCK_50);
            chk($sformatf("m%0d idle busy", k), 32'(Busy), 32'd0);
        end

        // Registered byte port on the Fb=105, Fx=15 snapshot
        for (int k = 0; k < 8; k++) begin
            Rd_Sel = rvec[k].sel;
            @(negedge CLOCK_50);
            chk($sformatf("rd sel %0d", rvec[k].sel), 32'(Rd_Data), 32'(rvec[k].exp));
        end
        Rd_Sel = 3'b000;
        #1;
        chk("rd latency old", 32'(Rd_Data), 32'h00);
        @(negedge CLOCK_50);
        chk("rd latency new", 32'(Rd_Data), 32'h69);

        // Continuous mode with stray Start pulses while busy
        fx_period = 10;
        Cont = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        measure(1'b1, cyc, ok);
        chk("cont first valid", 32'(ok), 32'd1);
        Ack = 1'b1;
        @(negedge CLOCK_50);
        Ack = 1'b0;
        chk("cont clr pulse", 32'({Cnt_Clr, Data_Valid, Busy}), 32'b101);
        clr_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            Start = (i % 3 == 0);
            @(negedge CLOCK_50);
            clr_cnt += int'(Cnt_Clr);
        end
        Start = 1'b0;
        chk("cont single clr", 32'(clr_cnt), 32'd0);
        measure(1'b0, cyc, ok);
        chk("cont second valid", 32'(ok), 32'd1);
        read_snap(1'b0, v);
        chk("cont fb", v, 32'd100);
        read_snap(1'b1, v);
        chk("cont fx", v, 32'd10);
        Cont = 1'b0;
        Ack  = 1'b1;
        @(negedge CLOCK_50);
        Ack = 1'b0;
        @(negedge CLOCK_50);
        chk("cont stop busy", 32'({Busy, Data_Valid}), 32'd0);

        // Abort in the middle of the gate
        Start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLOCK_50);
            Start = 1'b0;
            if (Cnt_En) begin
                ok = 1'b1;
                break;
            end
        end
        chk("abort gate open", 32'(ok), 32'd1);
        repeat (30) @(negedge CLOCK_50);
        Abort = 1'b1;
        @(negedge CLOCK_50);
        Abort = 1'b0;
        chk("abort outputs", 32'({Cnt_En, Busy, Data_Valid, Timeout}), 32'd0);
        read_snap(1'b0, v);
        chk("abort fb kept", v, 32'd100);
        read_snap(1'b1, v);
        chk("abort fx kept", v, 32'd10);
        Start = 1'b1;
        Abort = 1'b1;
        @(negedge CLOCK_50);
        Start = 1'b0;
        Abort = 1'b0;
        @(negedge CLOCK_50);
        chk("abort beats start", 32'({Busy, Cnt_Clr}), 32'd0);

        // Asynchronous reset during CLOSE
        Rd_Sel = 3'b000;
        fx_period = 7;
        repeat (20) @(negedge CLOCK_50);
        chk("pre-reset rd", 32'(Rd_Data), 32'h64);
        Start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLOCK_50);
            Start = 1'b0;
            if (Cnt_En && Cnt_Fb_In == 32'd102) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach close", 32'(ok), 32'd1);
        #2;
        RST_n = 1'b0;
        #1;
        chk("async reset outputs",
            32'({Fx_Edge, Cnt_Clr, Cnt_En, Busy, Data_Valid, Timeout, Rd_Data}), 32'd0);
        @(negedge CLOCK_50);
        RST_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK_50);
            bad += int'(Busy | Cnt_En | Cnt_Clr | Data_Valid);
        end
        chk("idle after reset", 32'(bad), 32'd0);
        measure(1'b1, cyc, ok);
        chk("post-reset valid", 32'(ok), 32'd1);
        read_snap(1'b0, v);
        chk("post-reset fb", v, 32'd105);
        read_snap(1'b1, v);
        chk("post-reset fx", v, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_meas_sequencer.md
Name: freq_meas_sequencer

Overview:
Measurement controller for the equal-precision frequency counter datapath, running entirely in the CLOCK_50 domain. It synchronises Fx, opens and closes the counting gate on Fx rising edges, and clears and enables the external Fb/Fx counters. It snapshots their 32-bit results, detects a missing Fx with a timeout, and presents the results to the MCU through a valid/ack handshake and a registered byte-read port.

Parameters:
GATE_CYCLES, 50_000_000, minimum gate length in CLOCK_50 cycles (1 s at 50 MHz)
TIMEOUT_CYCLES, 100_000_000, maximum wait for an Fx edge in ARM or CLOSE
CNT_W, 32, width of the datapath counters and snapshots

Ports:
CLOCK_50  in  1  system clock, 50 MHz
RST_n  in  1  asynchronous active-low reset
Start  in  1  one-cycle pulse from the MCU; starts a measurement
Cont  in  1  continuous mode; after Ack, start the next measurement automatically
Abort  in  1  synchronous abort to IDLE
Fx  in  1  asynchronous measured signal
Fx_Edge  out  1  one-cycle synchronised Fx rising-edge pulse, counted by the datapath
Cnt_Clr  out  1  synchronous clear of both datapath counters
Cnt_En  out  1  gate: datapath counts CLOCK_50 cycles and Fx_Edge pulses while high
Cnt_Fb_In  in  CNT_W  datapath Fb count
Cnt_Fx_In  in  CNT_W  datapath Fx count
Busy  out  1  measurement in progress
Data_Valid  out  1  snapshot ready for the MCU
Timeout  out  1  last measurement failed because no Fx edge arrived
Ack  in  1  MCU has consumed the snapshot
Rd_Sel  in  3  [2]: 0=Fb, 1=Fx; [1:0]: byte index, 0 = LSB
Rd_Data  out  8  registered byte of the snapshot

Behaviour:
- Reset (async, RST_n low): state IDLE; all outputs 0; snapshots 0; timers 0.
- Fx path: 2-FF synchroniser, then an edge register. Fx_Edge is high 3 cycles after the Fx pin rises. Fx must be below 12.5 MHz.
- States and transitions:
  - IDLE: on Start, or on auto-restart, go to CLEAR.
  - CLEAR: Cnt_Clr=1 for one cycle, then go to ARM.
  - ARM: wait for Fx_Edge. On the edge go to GATE; Cnt_En rises the next cycle, so the opening edge is not counted.
  - GATE: Cnt_En=1; the gate timer counts from 1 to GATE_CYCLES. On the final timer cycle: if Fx_Edge is also high, go to LATCH (that edge is counted and closes the gate); otherwise go to CLOSE.
  - CLOSE: Cnt_En=1 until the next Fx_Edge. That edge is counted; Cnt_En falls the following cycle and the state goes to LATCH.
  - LATCH: capture Cnt_Fb_In and Cnt_Fx_In into the snapshots. Data_Valid=1 and Timeout=0 from the next cycle. Go to DONE.
  - DONE: hold until Ack=1. Then clear Data_Valid next cycle and go to CLEAR if Cont=1, else IDLE.
  - ERR: entered from ARM or CLOSE when the timeout counter reaches TIMEOUT_CYCLES with no edge. Cnt_En=0, snapshots forced to 0, Data_Valid=1, Timeout=1. On Ack, Timeout and Data_Valid clear and the state goes to IDLE (Cont is ignored).
- The timeout counter restarts on every entry to ARM or CLOSE.
- Busy=1 in CLEAR, ARM, GATE, CLOSE and LATCH.
- Ignored inputs: Start is ignored unless in IDLE. Ack is ignored unless Data_Valid=1.
- Start coincident with Abort: Abort wins.
- Abort in any state: next cycle IDLE, Cnt_En=0, Data_Valid=0, Timeout=0; snapshots are retained.
- Start in the same cycle that Ack is accepted in DONE: ignored.
- Result relations: Fx count = N whole Fx periods; Fb count = N·Tx/Tclk; Fb count ≥ GATE_CYCLES unless timed out.
- Counters: the gate and timeout counters are wide enough for their parameter and saturate, never wrapping. Snapshots are CNT_W bits and are not modified.
- Rd_Data = byte Rd_Sel[1:0] of the snapshot selected by Rd_Sel[2], with 1-cycle registered latency. Valid in every state.

Decomposition:
- Shared package freq_meas_pkg: state enum (IDLE, CLEAR, ARM, GATE, CLOSE, LATCH, DONE, ERR), CNT_W default, Rd_Sel field constants.
- One sub-module: fx_edge_sync (2-FF synchroniser plus rising-edge pulse, async active-low reset).

Test Plan:
(All scenarios use GATE_CYCLES=100 and TIMEOUT_CYCLES=400.)
- Fx period 10 clk, Start → gate closes on the coincident 10th edge; snapshot Fb=100, Fx=10; Data_Valid=1, Timeout=0.
- Fx period 7 clk, Start → CLOSE waits for the 15th edge; Fb=105, Fx=15; Rd_Sel=3'b000 gives 0x69 one cycle later; Rd_Sel=3'b100 gives 0x0F.
- Fx held low, Start → after 400 cycles in ARM: Timeout=1, Data_Valid=1, all Rd_Data=0x00; Ack returns to IDLE with Timeout=0.
- Cont=1, Fx period 10 → after Ack: one Cnt_Clr pulse, a new measurement with identical results; Start pulses during Busy have no effect.
- Abort asserted mid-GATE → next cycle Cnt_En=0, Busy=0, Data_Valid=0, previous snapshot still readable.
- RST_n low mid-CLOSE → all outputs 0 immediately (asynchronously); after release the block stays IDLE until Start.
